// File: rtl/ahb_arb_pkg.sv
// Shared definitions for the AHB-Lite multi-master arbiter.
package ahb_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        PARK   = 2'd0,
        BUSY   = 2'd1,
        LOCKED = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ahb_rr_picker.sv
// Circular priority picker: returns the first asserted request at or after
// ptr, as a one-hot vector and as an index. Purely combinational.
module ahb_rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic found;

    // Scan two laps of the request vector starting at ptr; the first hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < 2 * N; i++) begin
            if (!found && i >= int'(ptr) && req[i % N]) begin
                found = 1'b1;
                idx   = IDX_W'(i % N);
            end
        end
        grant = found ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB-Lite arbiter sharing one ahb_node master port between NB_MASTERS masters.
// Tracks the address-phase owner (drives the bus fields) and the data-phase
// owner (drives hwdata, receives hresp). Non-owners that request are stalled.
// Build option: AHB_ARB_FIXED_PRIO_EN selects lowest-index-wins arbitration;
// otherwise arbitration is round-robin.
//
// state  | meaning
// PARK   | owner idle, bus may be handed to another requester
// BUSY   | owner issuing NONSEQ/SEQ/BUSY, grant held
// LOCKED | owner asserting hmastlock, grant held
module ahb_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NB_MASTERS     = 4,
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32
) (
    input  logic                                          hclk,
    input  logic                                          hreset,
    input  logic [NB_MASTERS-1:0][AHB_ADDR_WIDTH-1:0]     mst_hadrr_i,
    input  logic [NB_MASTERS-1:0][AHB_DATA_WIDTH-1:0]     mst_hwdata_i,
    input  logic [NB_MASTERS-1:0]                         mst_hwrite_i,
    input  logic [NB_MASTERS-1:0]                         mst_hmastlock_i,
    input  logic [NB_MASTERS-1:0][1:0]                    mst_htrans_i,
    input  logic [NB_MASTERS-1:0][3:0]                    mst_hprot_i,
    input  logic [NB_MASTERS-1:0][2:0]                    mst_hburst_i,
    input  logic [NB_MASTERS-1:0][2:0]                    mst_hsize_i,
    output logic [NB_MASTERS-1:0]                         mst_hready_o,
    output logic [NB_MASTERS-1:0]                         mst_hresp_o,
    output logic [AHB_DATA_WIDTH-1:0]                     mst_hrdata_o,
    output logic [NB_MASTERS-1:0]                         hgrant_o,
    output logic [AHB_ADDR_WIDTH-1:0]                     hadrr_o,
    output logic [AHB_DATA_WIDTH-1:0]                     hwdata_o,
    output logic                                          hwrite_o,
    output logic                                          hmastlock_o,
    output logic [1:0]                                    htrans_o,
    output logic [3:0]                                    hprot_o,
    output logic [2:0]                                    hburst_o,
    output logic [2:0]                                    hsize_o,
    output logic                                          hsel_o,
    output logic                                          hready_o,
    input  logic                                          hready_i,
    input  logic                                          hresp_i,
    input  logic [AHB_DATA_WIDTH-1:0]                     hrdata_i
);

    localparam int IDX_W = $clog2(NB_MASTERS);

    logic [IDX_W-1:0]      addr_owner;
    logic [IDX_W-1:0]      data_owner;
    logic                  data_valid;
    logic [IDX_W-1:0]      rr_ptr;
    arb_state_e            state;
    arb_state_e            next_state;

    logic [NB_MASTERS-1:0] req;
    logic [NB_MASTERS-1:0] pick_grant;
    logic [IDX_W-1:0]      pick_idx;
    logic [IDX_W-1:0]      ptr_next;
    logic [1:0]            owner_htrans;
    logic                  owner_lock;
    logic                  regrant;

    // A master asks for the bus with NONSEQ or SEQ; the owner is idle when
    // a switch is allowed, so it never appears in this vector at that time.
    always_comb begin
        req = '0;
        for (int m = 0; m < NB_MASTERS; m++) begin
            req[m] = mst_htrans_i[m][1];
        end
    end

    assign owner_htrans = mst_htrans_i[addr_owner];
    assign owner_lock   = mst_hmastlock_i[addr_owner];

    // In fixed-priority builds rr_ptr stays at 0, so the picker always
    // favours the lowest index.
    ahb_rr_picker #(
        .N     (NB_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    assign ptr_next = (pick_idx == IDX_W'(NB_MASTERS - 1)) ? '0 : pick_idx + IDX_W'(1);

    // Owner status tracking and the decision to hand the bus over.
    always_comb begin
        next_state = state;
        regrant    = 1'b0;
        case (state)
            PARK: begin
                if (owner_lock) begin
                    next_state = LOCKED;
                end else if (owner_htrans == HTRANS_NONSEQ || owner_htrans == HTRANS_SEQ ||
                             owner_htrans == HTRANS_BUSY) begin
                    next_state = BUSY;
                end else begin
                    regrant = |pick_grant;
                end
            end
            BUSY: begin
                if (owner_lock) begin
                    next_state = LOCKED;
                end else if (owner_htrans == HTRANS_IDLE) begin
                    next_state = PARK;
                    regrant    = |pick_grant;
                end
            end
            LOCKED: begin
                if (!owner_lock) begin
                    if (owner_htrans == HTRANS_IDLE) begin
                        next_state = PARK;
                        regrant    = |pick_grant;
                    end else begin
                        next_state = BUSY;
                    end
                end
            end
            default: next_state = PARK;
        endcase
    end

    // Ownership registers advance only when the slave completes a phase.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state      <= PARK;
            addr_owner <= '0;
            data_owner <= '0;
            data_valid <= 1'b0;
            rr_ptr     <= '0;
        end else if (hready_i) begin
            state      <= next_state;
            data_owner <= addr_owner;
            data_valid <= owner_htrans[1];
            if (regrant) begin
                addr_owner <= pick_idx;
`ifndef AHB_ARB_FIXED_PRIO_EN
                rr_ptr     <= ptr_next;
`endif
            end
        end
    end

    assign hgrant_o     = NB_MASTERS'(1) << addr_owner;
    assign hadrr_o      = mst_hadrr_i[addr_owner];
    assign hwrite_o     = mst_hwrite_i[addr_owner];
    assign hmastlock_o  = owner_lock;
    assign htrans_o     = owner_htrans;
    assign hprot_o      = mst_hprot_i[addr_owner];
    assign hburst_o     = mst_hburst_i[addr_owner];
    assign hsize_o      = mst_hsize_i[addr_owner];
    assign hwdata_o     = mst_hwdata_i[data_owner];
    assign hsel_o       = 1'b1;
    assign hready_o     = hready_i;
    assign mst_hrdata_o = hrdata_i;

    // Owner sees the slave's ready; requesting non-owners are held off;
    // a response only reaches the master with an open data phase.
    always_comb begin
        mst_hready_o = '0;
        mst_hresp_o  = '0;
        for (int m = 0; m < NB_MASTERS; m++) begin
            if (addr_owner == IDX_W'(m)) begin
                mst_hready_o[m] = hready_i;
            end else if (mst_htrans_i[m][1]) begin
                mst_hready_o[m] = 1'b0;
            end else begin
                mst_hready_o[m] = 1'b1;
            end
            mst_hresp_o[m] = (data_valid && data_owner == IDX_W'(m)) ? hresp_i : 1'b0;
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter with four masters.
module tb_ahb_arbiter;
    import ahb_arb_pkg::*;

    logic              hclk;
    logic              hreset;
    logic [3:0][31:0]  addr;
    logic [3:0][31:0]  wdata;
    logic [3:0]        write;
    logic [3:0]        lock;
    logic [3:0][1:0]   trans;
    logic [3:0][3:0]   prot;
    logic [3:0][2:0]   burst;
    logic [3:0][2:0]   size;
    logic [3:0]        mst_hready;
    logic [3:0]        mst_hresp;
    logic [31:0]       mst_hrdata;
    logic [3:0]        hgrant;
    logic [31:0]       bus_addr;
    logic [31:0]       bus_wdata;
    logic              bus_write;
    logic              bus_lock;
    logic [1:0]        bus_trans;
    logic [3:0]        bus_prot;
    logic [2:0]        bus_burst;
    logic [2:0]        bus_size;
    logic              hsel;
    logic              hready_loop;
    logic              hready_in;
    logic              hresp_in;
    logic [31:0]       hrdata_in;

    int n_checks = 0;
    int n_fail   = 0;

    ahb_arbiter #(
        .NB_MASTERS     (4),
        .AHB_ADDR_WIDTH (32),
        .AHB_DATA_WIDTH (32)
    ) dut (
        .hclk            (hclk),
        .hreset          (hreset),
        .mst_hadrr_i     (addr),
        .mst_hwdata_i    (wdata),
        .mst_hwrite_i    (write),
        .mst_hmastlock_i (lock),
        .mst_htrans_i    (trans),
        .mst_hprot_i     (prot),
        .mst_hburst_i    (burst),
        .mst_hsize_i     (size),
        .mst_hready_o    (mst_hready),
        .mst_hresp_o     (mst_hresp),
        .mst_hrdata_o    (mst_hrdata),
        .hgrant_o        (hgrant),
        .hadrr_o         (bus_addr),
        .hwdata_o        (bus_wdata),
        .hwrite_o        (bus_write),
        .hmastlock_o     (bus_lock),
        .htrans_o        (bus_trans),
        .hprot_o         (bus_prot),
        .hburst_o        (bus_burst),
        .hsize_o         (bus_size),
        .hsel_o          (hsel),
        .hready_o        (hready_loop),
        .hready_i        (hready_in),
        .hresp_i         (hresp_in),
        .hrdata_i        (hrdata_in)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    int quota[4];
    logic idle_next[4];
    int order[$];
    int exp_order[5];
    int n_exp;

    initial begin
        hreset    = 1'b1;
        hready_in = 1'b1;
        hresp_in  = 1'b0;
        hrdata_in = 32'h1234_5678;
        for (int m = 0; m < 4; m++) begin
            addr[m]  = 32'h1000 * (m + 1);
            wdata[m] = 32'hD0D0_0000 + m;
            trans[m] = HTRANS_IDLE;
            prot[m]  = 4'h0;
            burst[m] = 3'h0;
            size[m]  = 3'h2;
        end
        write   = '0;
        lock    = '0;
        addr[0] = 32'h0000_0A00;

        repeat (2) @(posedge hclk);
        #1;
        chk("rst_grant",  hgrant,      32'h1);
        chk("rst_hready", mst_hready,  32'hF);
        chk("rst_addr",   bus_addr,    32'hA00);
        chk("rst_hresp",  mst_hresp,   32'h0);
        chk("hsel",       hsel,        32'h1);
        chk("hready_lb",  hready_loop, 32'h1);
        chk("hrdata",     mst_hrdata,  32'h1234_5678);
        hreset = 1'b0;
        step();

        // Single request from M1 while M0 owns an idle bus
        trans[1] = HTRANS_NONSEQ;
        addr[1]  = 32'h100;
        prot[1]  = 4'h3;
        #1;
        chk("m1_stall",    mst_hready, 32'hD);
        chk("m1_pregrant", hgrant,     32'h1);
        step();
        chk("m1_grant",  hgrant,     32'h2);
        chk("m1_addr",   bus_addr,   32'h100);
        chk("m1_trans",  bus_trans,  32'(HTRANS_NONSEQ));
        chk("m1_prot",   bus_prot,   32'h3);
        chk("m1_hready", mst_hready, 32'hF);
        step();
        trans[1] = HTRANS_IDLE;
        #1;
        chk("park_m1", hgrant, 32'h2);
        step();

        // M0 INCR4 burst, M2 requests at beat 2
        trans[0] = HTRANS_NONSEQ;
        addr[0]  = 32'h200;
        burst[0] = 3'b011;
        #1;
        chk("m0_stall", mst_hready, 32'hE);
        step();
        chk("m0_grant", hgrant,   32'h1);
        chk("m0_addr",  bus_addr, 32'h200);
        chk("m0_burst", bus_burst, 32'h3);
        step();
        trans[0] = HTRANS_SEQ;
        addr[0]  = 32'h204;
        trans[2] = HTRANS_NONSEQ;
        addr[2]  = 32'h300;
        write[2] = 1'b1;
        #1;
        chk("burst_b2_stall", mst_hready, 32'hB);
        step();
        addr[0] = 32'h208;
        #1;
        chk("burst_b3_grant", hgrant,     32'h1);
        chk("burst_b3_stall", mst_hready, 32'hB);
        step();
        addr[0] = 32'h20C;
        #1;
        chk("burst_b4_grant", hgrant, 32'h1);
        step();
        trans[0] = HTRANS_IDLE;
        #1;
        chk("burst_idle_stall", mst_hready, 32'hB);
        chk("burst_idle_grant", hgrant,     32'h1);
        step();
        chk("m2_grant",  hgrant,     32'h4);
        chk("m2_addr",   bus_addr,   32'h300);
        chk("m2_write",  bus_write,  32'h1);
        chk("m2_hready", mst_hready, 32'hF);

        // M2 write data phase with three wait states and an ERROR response
        step();
        trans[2] = HTRANS_IDLE;
        wdata[2] = 32'hCAFE_0002;
        trans[1] = HTRANS_NONSEQ;
        addr[1]  = 32'h400;
        lock[1]  = 1'b1;
        hready_in = 1'b0;
        #1;
        chk("ws1_wdata",  bus_wdata,  32'hCAFE_0002);
        chk("ws1_hready", mst_hready, 32'h9);
        chk("ws1_grant",  hgrant,     32'h4);
        chk("ws1_hresp",  mst_hresp,  32'h0);
        step();
        wdata[0] = 32'hBAD0_0000;
        #1;
        chk("ws2_wdata", bus_wdata, 32'hCAFE_0002);
        chk("ws2_grant", hgrant,    32'h4);
        step();
        hresp_in = 1'b1;
        #1;
        chk("err1_hresp", mst_hresp, 32'h4);
        step();
        hready_in = 1'b1;
        #1;
        chk("err2_hresp",  mst_hresp,  32'h4);
        chk("err2_wdata",  bus_wdata,  32'hCAFE_0002);
        chk("err2_hready", mst_hready, 32'hD);
        step();
        hresp_in = 1'b0;
        #1;
        chk("lk_grant", hgrant,    32'h2);
        chk("lk_addr",  bus_addr,  32'h400);
        chk("lk_lock",  bus_lock,  32'h1);
        chk("lk_hresp", mst_hresp, 32'h0);

        // M1 locked sequence with an IDLE gap while M3 waits
        trans[3] = HTRANS_NONSEQ;
        addr[3]  = 32'h500;
        #1;
        chk("lk_m3_stall", mst_hready, 32'h7);
        step();
        trans[1] = HTRANS_IDLE;
        #1;
        chk("lk_gap_grant", hgrant,     32'h2);
        chk("lk_gap_stall", mst_hready, 32'h7);
        step();
        chk("lk_hold", hgrant, 32'h2);
        trans[1] = HTRANS_NONSEQ;
        addr[1]  = 32'h404;
        #1;
        chk("lk_addr2", bus_addr, 32'h404);
        step();
        trans[1] = HTRANS_IDLE;
        lock[1]  = 1'b0;
        #1;
        chk("lk_release_grant", hgrant, 32'h2);
        step();
        chk("m3_grant", hgrant,   32'h8);
        chk("m3_addr",  bus_addr, 32'h500);
        chk("m3_lock",  bus_lock, 32'h0);

        // Reset while M3 holds the address phase
        hreset = 1'b1;
        #1;
        chk("rstmid_grant",  hgrant,     32'h1);
        chk("rstmid_trans",  bus_trans,  32'(HTRANS_IDLE));
        chk("rstmid_hready", mst_hready, 32'h7);
        chk("rstmid_wdata",  bus_wdata,  32'hBAD0_0000);
        for (int m = 0; m < 4; m++) begin
            trans[m] = HTRANS_IDLE;
            addr[m]  = 32'h800 + 32'h10 * m;
        end
        write = '0;
        lock  = '0;
        step();
        hreset = 1'b0;
        step();

        // Everyone requests at once; each master idles one cycle after a transfer
`ifdef AHB_ARB_FIXED_PRIO_EN
        quota     = '{3, 3, 1, 1};
        exp_order = '{0, 1, 0, 1, 0};
        n_exp     = 4;
`else
        quota     = '{2, 1, 1, 1};
        exp_order = '{0, 1, 2, 3, 0};
        n_exp     = 5;
`endif
        for (int m = 0; m < 4; m++) begin
            idle_next[m] = 1'b0;
            trans[m]     = (quota[m] > 0) ? HTRANS_NONSEQ : HTRANS_IDLE;
        end
        for (int c = 0; c < 40 && order.size() < n_exp; c++) begin
            #1;
            for (int m = 0; m < 4; m++) begin
                if (trans[m] == HTRANS_NONSEQ && mst_hready[m]) begin
                    order.push_back(m);
                    quota[m]--;
                    idle_next[m] = 1'b1;
                end
            end
            step();
            for (int m = 0; m < 4; m++) begin
                if (idle_next[m]) begin
                    trans[m]     = HTRANS_IDLE;
                    idle_next[m] = 1'b0;
                end else begin
                    trans[m] = (quota[m] > 0) ? HTRANS_NONSEQ : HTRANS_IDLE;
                end
            end
        end
        if (order.size() < n_exp) begin
            chk("rr_timeout", order.size(), n_exp);
        end
        for (int i = 0; i < n_exp && i < order.size(); i++) begin
            chk($sformatf("order_%0d", i), order[i], exp_order[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
